alu8: RTL and testbench
=======================

# alu8

8-bit two-operand arithmetic/logic unit with registered result and carry outputs. Computes one of four operations on operands `a` and `b`, selected by a 2-bit opcode, and presents the result one clock after the operands are sampled. Used as the datapath compute element. Surrounding logic drives the opcode and operands and consumes the result and carry.

## Interface
Parameters:
- none. The datapath width is fixed at 8 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `opcode`  in  2  operation select.
- `a`  in  8  operand A, unsigned.
- `b`  in  8  operand B, unsigned.
- `res`  out  8  registered result.
- `carry`  out  1  registered carry/borrow flag.

The design uses one clock. Reset is synchronous and active-low.

## Operation
Opcode decode:
- 2'b00 ADD: `{carry, res} = a + b`, computed 9 bits wide. `carry` is bit 8 (unsigned carry-out).
- 2'b01 SUB: `res = (a - b) mod 256`. `carry = 1` when a < b (borrow), else 0.
- 2'b10 AND: `res = a & b` bitwise. `carry = 0`.
- 2'b11 OR: `res = a | b` bitwise. `carry = 0`.

Width and arithmetic rules:
- All operands are unsigned. There is no overflow or sign flag.
- ADD wraps modulo 256; the lost bit appears only in `carry`.
- SUB wraps modulo 256; `carry` is the borrow, not an inverted carry.
- Logic operations always clear `carry`.
- All four opcode values are defined, so no illegal-opcode state exists.
- There is no carry-in. The previous `carry` value never affects the next result.

## Timing
- Reset: while `rst_n` = 0 at a rising edge, `res` <= 8'h00 and `carry` <= 0. Reset has priority over any operation presented in the same cycle.
- Latency: exactly 1 cycle. `opcode`, `a` and `b` are sampled at rising edge N. The corresponding `res`/`carry` are valid after edge N and hold until edge N+1.
- Throughput: one operation per cycle, with no handshake and no stall.
- Outputs change only on clock edges. Combinational input glitches between edges are not visible at the outputs.
- Inputs may change every cycle. Each edge captures the operation on the inputs at that edge, independent of history.
- Release from reset: the first non-reset edge produces the result of the inputs present at that edge.
- Reset mid-stream: an operation presented in the same cycle that `rst_n` = 0 is discarded. The outputs show zero for that cycle.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with opcode=00, a=8'hFF, b=8'h01 -> res=8'h00, carry=0. After release, the next edge gives res=8'h00, carry=1.
- ADD boundaries: 00 with a=100, b=55 -> res=155, carry=0. 00 with a=255, b=1 -> res=0, carry=1. 00 with a=255, b=255 -> res=254, carry=1.
- SUB boundaries: 01 with a=10, b=3 -> res=7, carry=0. 01 with a=0, b=1 -> res=255, carry=1. 01 with a=200, b=200 -> res=0, carry=0.
- Logic: 10 with a=8'hF0, b=8'h3C -> res=8'h30, carry=0. 11 with a=0, b=255 -> res=255, carry=0. 11 with a=8'hA5, b=8'h5A -> res=8'hFF, carry=0.
- Latency/back-to-back: change the opcode and operands every cycle through the sequence ADD 255+1, AND FF&0F, SUB 0-1 -> outputs lag the inputs by exactly one edge: (0,1), (8'h0F,0), (255,1). A carry from ADD must not leak into the following AND.
- Mid-stream reset: assert `rst_n`=0 for one cycle during the sequence above -> outputs are zero for that cycle. The next valid operation appears one edge after release.

Source files
------------

// File: rtl/alu8.sv
// 8-bit unsigned ALU: ADD, SUB, AND and OR selected by opcode.
// The result and carry/borrow are registered, so they appear one clock after the inputs are sampled.
module alu8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] opcode,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] res,
   output logic       carry
);

   localparam int unsigned W = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   logic [W-1:0] res_d, res_q;
   logic         carry_d, carry_q;
   logic [W:0]   sum_c;
   logic [W:0]   diff_c;

   // Nine-bit add and subtract: bit W is the carry-out, or the borrow when a < b.
   always_comb begin
      sum_c  = {1'b0, a} + {1'b0, b};
      diff_c = {1'b0, a} - {1'b0, b};
      res_d   = '0;
      carry_d = 1'b0;
      case (op_e'(opcode))
         OP_ADD: begin
            res_d   = sum_c[W-1:0];
            carry_d = sum_c[W];
         end
         OP_SUB: begin
            res_d   = diff_c[W-1:0];
            carry_d = diff_c[W];
         end
         OP_AND: res_d = a & b;
         OP_OR:  res_d = a | b;
         default: begin
            res_d   = '0;
            carry_d = 1'b0;
         end
      endcase
   end

   // Reset overrides the operation presented at the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         carry_q <= carry_d;
      end
   end

   assign res   = res_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed boundary cases, back-to-back and reset sequences,
// and random traffic compared against an arithmetic reference model.
module tb_alu8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] opcode = 2'b00;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [7:0] res;
   logic       carry;

   int vectors = 0;
   int miscompares = 0;

   alu8 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opcode (opcode),
      .a      (a),
      .b      (b),
      .res    (res),
      .carry  (carry)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, returns {carry, res}.
   function automatic logic [8:0] model(input logic rn, input logic [1:0] op,
                                        input int unsigned x, input int unsigned y);
      int unsigned r;
      int unsigned c;
      if (!rn) return 9'h000;
      r = 0;
      c = 0;
      case (op)
         2'd0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
         2'd1: begin r = (x + 256 - y) % 256; c = (x < y) ? 1 : 0; end
         2'd2: r = x & y;
         default: r = x | y;
      endcase
      return {1'(c), 8'(r)};
   endfunction

   // Present inputs at the falling edge, then step past the next rising edge.
   task automatic drive(input logic rn, input logic [1:0] op,
                        input logic [7:0] aa, input logic [7:0] bb);
      @(negedge clk);
      rst_n  = rn;
      opcode = op;
      a      = aa;
      b      = bb;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 2'b00, 8'hFF, 8'h01);
      drive(1'b0, 2'b00, 8'hFF, 8'h01);
      vectors++;
      if ({carry, res} !== 9'h000) begin
         miscompares++;
         $display("FAIL reset_hold: got carry=%0b res=%02h, want carry=0 res=00", carry, res);
      end
      drive(1'b1, 2'b00, 8'hFF, 8'h01);
      vectors++;
      if ({carry, res} !== {1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_release: got carry=%0b res=%02h, want carry=1 res=00", carry, res);
      end
   endtask

   task automatic test_directed(input string name, input logic [1:0] op,
                                input logic [7:0] aa, input logic [7:0] bb,
                                input logic [7:0] want_r, input logic want_c);
      drive(1'b1, op, aa, bb);
      vectors++;
      if ({carry, res} !== {want_c, want_r}) begin
         miscompares++;
         $display("FAIL %s: a=%02h b=%02h got carry=%0b res=%02h, want carry=%0b res=%02h",
                  name, aa, bb, carry, res, want_c, want_r);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops [3] = '{2'b00, 2'b10, 2'b01};
      logic [7:0] as  [3] = '{8'hFF, 8'hFF, 8'h00};
      logic [7:0] bs  [3] = '{8'h01, 8'h0F, 8'h01};
      logic [8:0] want [3] = '{{1'b1, 8'h00}, {1'b0, 8'h0F}, {1'b1, 8'hFF}};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ops[i], as[i], bs[i]);
         vectors++;
         if ({carry, res} !== want[i]) begin
            miscompares++;
            $display("FAIL b2b_step%0d: got carry=%0b res=%02h, want carry=%0b res=%02h",
                     i, carry, res, want[i][8], want[i][7:0]);
         end
         // Outputs must hold until the next rising edge even though inputs change.
         @(negedge clk);
         opcode = 2'b11;
         a = 8'hAA;
         b = 8'h55;
         #2;
         vectors++;
         if ({carry, res} !== want[i]) begin
            miscompares++;
            $display("FAIL b2b_hold%0d: got carry=%0b res=%02h, want carry=%0b res=%02h",
                     i, carry, res, want[i][8], want[i][7:0]);
         end
      end
   endtask

   task automatic test_midstream_reset();
      logic       rns  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] ops  [4] = '{2'b00, 2'b10, 2'b01, 2'b10};
      logic [7:0] as   [4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
      logic [7:0] bs   [4] = '{8'h01, 8'h0F, 8'h01, 8'h0F};
      logic [8:0] want [4] = '{{1'b1, 8'h00}, 9'h000, {1'b1, 8'hFF}, {1'b0, 8'h0F}};
      for (int i = 0; i < 4; i++) begin
         drive(rns[i], ops[i], as[i], bs[i]);
         vectors++;
         if ({carry, res} !== want[i]) begin
            miscompares++;
            $display("FAIL midrst_step%0d: got carry=%0b res=%02h, want carry=%0b res=%02h",
                     i, carry, res, want[i][8], want[i][7:0]);
         end
      end
   endtask

   task automatic test_random();
      logic       rn;
      logic [1:0] op;
      logic [7:0] aa, bb;
      logic [8:0] want;
      for (int i = 0; i < 400; i++) begin
         rn = ($urandom_range(0, 15) != 0);
         op = 2'($urandom_range(0, 3));
         aa = 8'($urandom);
         bb = 8'($urandom);
         if ((i % 50) == 7) aa = bb;
         want = model(rn, op, aa, bb);
         drive(rn, op, aa, bb);
         vectors++;
         if ({carry, res} !== want) begin
            miscompares++;
            $display("FAIL random%0d: rst_n=%0b op=%0d a=%02h b=%02h got carry=%0b res=%02h, want carry=%0b res=%02h",
                     i, rn, op, aa, bb, carry, res, want[8], want[7:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("add_plain",  2'b00, 8'd100, 8'd55,  8'd155, 1'b0);
      test_directed("add_wrap",   2'b00, 8'd255, 8'd1,   8'd0,   1'b1);
      test_directed("add_max",    2'b00, 8'd255, 8'd255, 8'd254, 1'b1);
      test_directed("sub_plain",  2'b01, 8'd10,  8'd3,   8'd7,   1'b0);
      test_directed("sub_borrow", 2'b01, 8'd0,   8'd1,   8'd255, 1'b1);
      test_directed("sub_equal",  2'b01, 8'd200, 8'd200, 8'd0,   1'b0);
      test_directed("add_carry",  2'b00, 8'd128, 8'd128, 8'd0,   1'b1);
      test_directed("and_mix",    2'b10, 8'hF0,  8'h3C,  8'h30,  1'b0);
      test_directed("or_zero",    2'b11, 8'h00,  8'hFF,  8'hFF,  1'b0);
      test_directed("or_alt",     2'b11, 8'hA5,  8'h5A,  8'hFF,  1'b0);
      test_directed("and_full",   2'b10, 8'hFF,  8'hFF,  8'hFF,  1'b0);
      test_back_to_back();
      test_midstream_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
